// File: rtl/sram_copy_if.sv
// ---------------------------------------------------------------------------
// sram_copy_if
// Bundles the request/status signals and the SRAM port of the copy engine.
//   master : the copy engine (consumes requests and read data, drives status
//            and the SRAM write/address port)
//   slave  : the environment (requester plus SRAM)
// Signals:
//   start, mode, src_addr, dst_addr, len, fill_byte, abort  -- request side
//   busy, done, bytes_done                                 -- status
//   sram_w_en, sram_w_mask, sram_address, sram_write_data  -- SRAM command
//   sram_read_data                                         -- SRAM read data
// ---------------------------------------------------------------------------
interface sram_copy_if;
  logic         start;
  logic         mode;
  logic [15:0]  src_addr;
  logic [15:0]  dst_addr;
  logic [15:0]  len;
  logic [7:0]   fill_byte;
  logic         abort;
  logic         busy;
  logic         done;
  logic [15:0]  bytes_done;
  logic         sram_w_en;
  logic [15:0]  sram_w_mask;
  logic [15:0]  sram_address;
  logic [511:0] sram_write_data;
  logic [511:0] sram_read_data;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_byte, abort, sram_read_data,
    output busy, done, bytes_done, sram_w_en, sram_w_mask, sram_address, sram_write_data
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_byte, abort, sram_read_data,
    input  busy, done, bytes_done, sram_w_en, sram_w_mask, sram_address, sram_write_data
  );
endinterface

// File: rtl/sram_copy_engine.sv
// ---------------------------------------------------------------------------
// sram_copy_engine
// Copies (mode 0) or fills (mode 1) a byte range of a 16-byte-line SRAM.
// Copy alternates READ (capture one source line) and WRITE (store it at the
// destination); fill issues back-to-back WRITEs of the replicated fill byte.
// The last line is trimmed with a per-byte write mask.
// Ports:
//   clk    -- single clock, rising edge
//   rst_n  -- asynchronous active-low reset
//   bus    -- sram_copy_if.master: request, status and SRAM port
// ---------------------------------------------------------------------------
module sram_copy_engine (
  input  logic        clk,
  input  logic        rst_n,
  sram_copy_if.master bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;

  state_e       state_q, state_d;
  logic [15:0]  src_ptr_q, src_ptr_d;
  logic [15:0]  dst_ptr_q, dst_ptr_d;
  logic [15:0]  remaining_q, remaining_d;
  logic [15:0]  bytes_done_q, bytes_done_d;
  logic         mode_q, mode_d;
  logic [7:0]   fill_q, fill_d;
  logic [127:0] line_q, line_d;

  logic [15:0]  chunk;
  logic [15:0]  line_mask;
  logic [127:0] fill_line;

  logic         busy_o, done_o, w_en_o;
  logic [15:0]  mask_o, addr_o;
  logic [127:0] wdata_o;
  logic         unused_read_hi;

  // Only the low 16 bytes of the read bus belong to a line.
  assign unused_read_hi = ^bus.sram_read_data[511:128];

  assign chunk = (remaining_q >= 16'd16) ? 16'd16 : remaining_q;

  // Byte lane gi is written while more than gi bytes remain; this yields
  // 16'hFFFF for full lines and (1<<remaining)-1 for the tail line.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
      assign line_mask[gi]         = (remaining_q > 16'(gi));
      assign fill_line[8*gi +: 8]  = fill_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      remaining_q  <= '0;
      bytes_done_q <= '0;
      mode_q       <= 1'b0;
      fill_q       <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      remaining_q  <= remaining_d;
      bytes_done_q <= bytes_done_d;
      mode_q       <= mode_d;
      fill_q       <= fill_d;
      line_q       <= line_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    remaining_d  = remaining_q;
    bytes_done_d = bytes_done_q;
    mode_d       = mode_q;
    fill_d       = fill_q;
    line_d       = line_q;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    w_en_o       = 1'b0;
    mask_o       = '0;
    addr_o       = '0;
    wdata_o      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          src_ptr_d    = bus.src_addr;
          dst_ptr_d    = bus.dst_addr;
          remaining_d  = bus.len;
          mode_d       = bus.mode;
          fill_d       = bus.fill_byte;
          bytes_done_d = '0;
          if (bus.len == 16'd0)  state_d = ST_DONE;
          else if (bus.mode)     state_d = ST_WRITE;
          else                   state_d = ST_READ;
        end
      end

      ST_READ: begin
        busy_o = 1'b1;
        addr_o = src_ptr_q;
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          line_d  = bus.sram_read_data[127:0];
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        busy_o  = 1'b1;
        addr_o  = dst_ptr_q;
        mask_o  = line_mask;
        wdata_o = mode_q ? fill_line : line_q;
        // Abort must suppress the write in the very cycle it is seen.
        w_en_o  = !bus.abort;
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          remaining_d  = remaining_q - chunk;
          bytes_done_d = bytes_done_q + chunk;
          src_ptr_d    = src_ptr_q + 16'd16;
          dst_ptr_d    = dst_ptr_q + 16'd16;
          if (remaining_q == chunk) state_d = ST_DONE;
          else if (mode_q)          state_d = ST_WRITE;
          else                      state_d = ST_READ;
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy            = busy_o;
  assign bus.done            = done_o;
  assign bus.bytes_done      = bytes_done_q;
  assign bus.sram_w_en       = w_en_o;
  assign bus.sram_w_mask     = mask_o;
  assign bus.sram_address    = addr_o;
  assign bus.sram_write_data = {384'd0, wdata_o};
endmodule

// File: doc/sram_copy_engine.md
SRAM_COPY_ENGINE -- requirements
Module: sram_copy_engine

Interface
REQ-001 Parameters: none; line width fixed at 16 bytes, address width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 mode  input  1  0 = copy (src to dst), 1 = fill (fill_byte to dst).
REQ-006 src_addr  input  16  source byte address; ignored in fill.
REQ-007 dst_addr  input  16  destination byte address.
REQ-008 len  input  16  transfer length in bytes.
REQ-009 fill_byte  input  8  fill pattern byte.
REQ-010 abort  input  1  terminate active transfer.
REQ-011 busy  output  1  high in READ and WRITE states.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 bytes_done  output  16  bytes written by the current or last transfer.
REQ-014 sram_w_en  output  1  SRAM write enable.
REQ-015 sram_w_mask  output  16  per-byte write mask; bit i covers byte address+i.
REQ-016 sram_address  output  16  SRAM line base byte address.
REQ-017 sram_write_data  output  512  byte i on bits [8i+7:8i]; bits [511:128] always 0.
REQ-018 sram_read_data  input  512  combinational SRAM read data; byte i on bits [8i+7:8i].

Function
REQ-019 FSM states: IDLE, READ, WRITE, DONE.
REQ-020 IDLE with start=1: latch src_addr, dst_addr, len, mode, fill_byte into working registers; remaining=len; bytes_done=0.
REQ-021 IDLE transition on start: len=0 -> DONE; mode=0 -> READ; mode=1 -> WRITE.
REQ-022 start in any state other than IDLE is ignored; latched operands do not change.
REQ-023 READ: sram_address=src_ptr, sram_w_en=0; at clock edge capture sram_read_data[127:0] into line buffer; go to WRITE.
REQ-024 WRITE: sram_address=dst_ptr, sram_w_en=1; chunk=min(remaining,16); sram_w_mask=16'hFFFF if remaining>=16, else (1<<remaining)-1.
REQ-025 WRITE data: copy -> line buffer in bits [127:0]; fill -> fill_byte replicated 16 times in bits [127:0].
REQ-026 WRITE at clock edge: remaining-=chunk; bytes_done+=chunk; src_ptr+=16; dst_ptr+=16, all modulo 2^16.
REQ-027 WRITE transition: remaining-chunk=0 -> DONE; else copy -> READ, fill -> WRITE.
REQ-028 DONE: done=1 for exactly one cycle, busy=0, sram_w_en=0; then IDLE unconditionally.
REQ-029 Timing, with start sampled at edge E0 and k=ceil(len/16): copy done in cycle 2k+1 after E0; fill done in cycle k+1; len=0 done in cycle 1.
REQ-030 Throughput: copy 2 cycles per line, fill 1 cycle per line.
REQ-031 Abort in READ or WRITE: sram_w_en forced 0 combinationally in that cycle; no pointer or bytes_done update; IDLE at next edge; no done pulse.
REQ-032 Abort in IDLE or DONE has no effect.
REQ-033 Address wrap past 0xFFFF is delegated to the SRAM's byte addressing; pointers wrap mod 2^16.
REQ-034 Overlapping src/dst regions: no hazard detection; result equals strictly sequential line-by-line read-then-write order.
REQ-035 In IDLE and DONE: sram_w_en=0, sram_w_mask=0, sram_address=0, sram_write_data=0.

Reset
REQ-036 rst_n=0 asynchronously forces IDLE, busy=0, done=0, bytes_done=0, sram_w_en=0, sram_w_mask=0, sram_address=0, sram_write_data=0.
REQ-037 rst_n=0 also clears line buffer, pointers and remaining; an interrupted transfer is discarded.
REQ-038 First start is sampled at the first rising edge after rst_n deasserts.

Verification
REQ-039 Fill: dst=0x0100, len=20, fill=0xA5 -> cycle 1 write addr 0x0100 mask 0xFFFF; cycle 2 addr 0x0110 mask 0x000F; done in cycle 3; bytes_done=20.
REQ-040 Copy: mem[0x0000..0x000F]=0x00..0x0F, dst=0x0200, len=16 -> cycle 1 read addr 0x0000 with w_en=0; cycle 2 write addr 0x0200 mask 0xFFFF, data[127:0]=0x0F0E..0100; done in cycle 3.
REQ-041 len=0 -> w_en never asserted; done in cycle 1; bytes_done=0.
REQ-042 Fill: dst=0xFFF8, len=16, fill=0x3C -> one write at 0xFFF8; SRAM bytes 0xFFF8..0xFFFF and 0x0000..0x0007 read back 0x3C.
REQ-043 Copy len=48 with abort high during the second WRITE -> w_en=0 that cycle; IDLE next cycle; no done; bytes_done=16; a start pulse issued mid-transfer is ignored.
REQ-044 rst_n low during a fill WRITE -> w_en and all outputs 0 before the next edge; state is IDLE after release.
